// File: rtl/input_pkg.sv
// Shared types and helpers for the input-conditioning blocks.
package input_pkg;

    // Per-channel long-press / auto-repeat state
    typedef enum logic [1:0] {
        HOLD_IDLE   = 2'd0,
        HOLD_WAIT   = 2'd1,
        HOLD_REPEAT = 2'd2
    } hold_state_t;

    // Bits needed to index 'value' distinct states, never less than one
    function automatic int clog2_min1(input int unsigned value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser, clears to 0 on reset.
module sync_chain #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_array.sv
// Multi-channel debouncer with press/release strobes and long-press auto-repeat.
module debounce_array
    import input_pkg::*;
#(
    parameter int unsigned         CHANNELS      = 4,
    parameter int unsigned         STABLE_CYCLES = 1048575,
    parameter int unsigned         SYNC_STAGES   = 2,
    parameter int unsigned         HOLD_CYCLES   = 50000000,
    parameter int unsigned         REPEAT_CYCLES = 10000000,
    parameter logic [CHANNELS-1:0] INVERT        = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] i_in,
    output logic [CHANNELS-1:0] o_state,
    output logic [CHANNELS-1:0] o_press,
    output logic [CHANNELS-1:0] o_release,
    output logic [CHANNELS-1:0] o_hold
);

    // Counter sizing; the stability counter must be able to reach STABLE_CYCLES
    localparam int unsigned C_W       = clog2_min1(STABLE_CYCLES + 1);
    localparam int unsigned H_MAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned H_W       = clog2_min1(H_MAX);
    localparam int unsigned HOLD_LAST = HOLD_CYCLES - 1;
    localparam bit          REP_EN    = (REPEAT_CYCLES != 0);
    localparam int unsigned REP_LAST  = REP_EN ? (REPEAT_CYCLES - 1) : 0;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic           w_x;
        logic           w_s;
        logic           w_accept;
        logic           w_rise;
        logic           w_fall;
        logic [H_W-1:0] w_h_inc;
        logic [C_W-1:0] r_cnt;
        logic           r_state;
        logic           r_press;
        logic           r_release;
        logic           r_hold;
        logic [H_W-1:0] r_h;
        hold_state_t    r_fsm;

        assign w_x = i_in[g] ^ INVERT[g];

        sync_chain #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk  (clk),
            .reset(reset),
            .i_d  (w_x),
            .o_q  (w_s)
        );

        // A differing level is accepted once it has survived the whole window
        assign w_accept = (w_s != r_state) && (r_cnt == C_W'(STABLE_CYCLES));
        assign w_rise   = w_accept & w_s;
        assign w_fall   = w_accept & ~w_s;
        assign w_h_inc  = (r_h == '1) ? r_h : r_h + 1'b1;

        // Stability window, debounced level and press/release strobes
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt     <= '0;
                r_state   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_press   <= w_rise;
                r_release <= w_fall;
                if (w_s == r_state) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_state <= w_s;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Long-press FSM; a release always wins over a coincident repeat
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_fsm  <= HOLD_IDLE;
                r_h    <= '0;
                r_hold <= 1'b0;
            end else begin
                r_hold <= 1'b0;
                if (w_fall) begin
                    r_fsm <= HOLD_IDLE;
                    r_h   <= '0;
                end else begin
                    case (r_fsm)
                        HOLD_IDLE: begin
                            if (w_rise) begin
                                r_fsm <= HOLD_WAIT;
                                r_h   <= '0;
                            end
                        end
                        HOLD_WAIT: begin
                            if (r_h == H_W'(HOLD_LAST)) begin
                                r_hold <= 1'b1;
                                r_h    <= '0;
                                r_fsm  <= HOLD_REPEAT;
                            end else begin
                                r_h <= w_h_inc;
                            end
                        end
                        HOLD_REPEAT: begin
                            // With repeat disabled this state just parks until release
                            if (REP_EN) begin
                                if (r_h == H_W'(REP_LAST)) begin
                                    r_hold <= 1'b1;
                                    r_h    <= '0;
                                end else begin
                                    r_h <= w_h_inc;
                                end
                            end
                        end
                        default: begin
                            r_fsm <= HOLD_IDLE;
                            r_h   <= '0;
                        end
                    endcase
                end
            end
        end

        assign o_state[g]   = r_state;
        assign o_press[g]   = r_press;
        assign o_release[g] = r_release;
        assign o_hold[g]    = r_hold;
    end

endmodule

// File: tb/tb_debounce_array.sv
// Scenario bench for debounce_array: three instances cover the default,
// repeat-disabled and inverted-input configurations.
module tb_debounce_array;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_a, in_b, in_c;
    logic [1:0] st_a, pr_a, rl_a, hd_a;
    logic [1:0] st_b, pr_b, rl_b, hd_b;
    logic [1:0] st_c, pr_c, rl_c, hd_c;

    // Expected {state, press, release, hold} per edge
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_array #(
        .CHANNELS(2), .STABLE_CYCLES(4), .SYNC_STAGES(2),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .INVERT(2'b00)
    ) u_dut_a (
        .clk(clk), .reset(reset), .i_in(in_a),
        .o_state(st_a), .o_press(pr_a), .o_release(rl_a), .o_hold(hd_a)
    );

    debounce_array #(
        .CHANNELS(2), .STABLE_CYCLES(4), .SYNC_STAGES(2),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(0), .INVERT(2'b00)
    ) u_dut_b (
        .clk(clk), .reset(reset), .i_in(in_b),
        .o_state(st_b), .o_press(pr_b), .o_release(rl_b), .o_hold(hd_b)
    );

    debounce_array #(
        .CHANNELS(2), .STABLE_CYCLES(4), .SYNC_STAGES(2),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .INVERT(2'b10)
    ) u_dut_c (
        .clk(clk), .reset(reset), .i_in(in_c),
        .o_state(st_c), .o_press(pr_c), .o_release(rl_c), .o_hold(hd_c)
    );

    function automatic logic [7:0] pk(input logic [1:0] s, input logic [1:0] p,
                                      input logic [1:0] r, input logic [1:0] h);
        return {s, p, r, h};
    endfunction

    // Pulse reset; called just after a sampling point, next posedge is edge 0
    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        #2;
        obs = {st_a, pr_a, rl_a, hd_a};
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_a: got %b want %b", obs, 8'h00); end
        obs = {st_b, pr_b, rl_b, hd_b};
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_b: got %b want %b", obs, 8'h00); end
        obs = {st_c, pr_c, rl_c, hd_c};
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_c: got %b want %b", obs, 8'h00); end
        @(posedge clk);
        #1;
        obs = {st_c, pr_c, rl_c, hd_c};
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_c_clocked: got %b want %b", obs, 8'h00); end
        reset = 1'b0;
    endtask

    task automatic test_clean_press();
        logic [7:0] exp, obs;
        in_a = 2'b00;
        apply_reset();
        in_a = 2'b01;
        for (int e = 0; e < 10; e++) begin
            exp_q.push_back(pk({1'b0, e >= 6}, {1'b0, e == 6}, 2'b00, 2'b00));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_a, pr_a, rl_a, hd_a};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL clean_press edge %0d: got %b want %b", e, obs, exp); end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp, obs;
        in_a = 2'b00;
        apply_reset();
        for (int e = 0; e < 30; e++) begin
            in_a = (e < 20) ? {1'b0, ((e / 2) % 2) == 0} : 2'b01;
            exp_q.push_back(pk({1'b0, e >= 26}, {1'b0, e == 26}, 2'b00, 2'b00));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_a, pr_a, rl_a, hd_a};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL bounce edge %0d: got %b want %b", e, obs, exp); end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp, obs;
        in_a = 2'b00;
        apply_reset();
        for (int e = 0; e < 15; e++) begin
            in_a = (e < 3) ? 2'b10 : 2'b00;
            exp_q.push_back(8'h00);
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_a, pr_a, rl_a, hd_a};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL glitch edge %0d: got %b want %b", e, obs, exp); end
        end
    endtask

    task automatic test_long_press();
        logic [7:0] exp, obs;
        logic       h;
        in_a = 2'b00;
        apply_reset();
        for (int e = 0; e < 46; e++) begin
            in_a = (e < 26) ? 2'b01 : 2'b00;
            h = (e == 16) || (e == 19) || (e == 22) || (e == 25) || (e == 28) || (e == 31);
            exp_q.push_back(pk({1'b0, (e >= 6) && (e < 32)}, {1'b0, e == 6},
                               {1'b0, e == 32}, {1'b0, h}));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_a, pr_a, rl_a, hd_a};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL long_press edge %0d: got %b want %b", e, obs, exp); end
        end
    endtask

    task automatic test_no_repeat();
        logic [7:0] exp, obs;
        in_b = 2'b00;
        apply_reset();
        for (int e = 0; e < 40; e++) begin
            in_b = (e < 30) ? 2'b01 : 2'b00;
            exp_q.push_back(pk({1'b0, (e >= 6) && (e < 36)}, {1'b0, e == 6},
                               {1'b0, e == 36}, {1'b0, e == 16}));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_b, pr_b, rl_b, hd_b};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL no_repeat edge %0d: got %b want %b", e, obs, exp); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp, obs;
        in_a = 2'b00;
        apply_reset();
        for (int e = 0; e < 21; e++) begin
            in_a = (e >= 18) ? 2'b11 : 2'b01;
            exp_q.push_back(pk({1'b0, e >= 6}, {1'b0, e == 6}, 2'b00,
                               {1'b0, (e == 16) || (e == 19)}));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_a, pr_a, rl_a, hd_a};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL reset_mid_pre edge %0d: got %b want %b", e, obs, exp); end
        end
        #2;
        reset = 1'b1;
        #1;
        obs = {st_a, pr_a, rl_a, hd_a};
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_mid_async: got %b want %b", obs, 8'h00); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int e = 0; e < 15; e++) begin
            exp_q.push_back(pk((e >= 6) ? 2'b11 : 2'b00, (e == 6) ? 2'b11 : 2'b00, 2'b00, 2'b00));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_a, pr_a, rl_a, hd_a};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL reset_mid_post edge %0d: got %b want %b", e, obs, exp); end
        end
    endtask

    task automatic test_invert();
        logic [7:0] exp, obs;
        in_c = 2'b10;
        apply_reset();
        for (int e = 0; e < 30; e++) begin
            in_c = ((e >= 4) && (e < 17)) ? 2'b00 : 2'b10;
            exp_q.push_back(pk({(e >= 10) && (e < 23), 1'b0}, {e == 10, 1'b0},
                               {e == 23, 1'b0}, {e == 20, 1'b0}));
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            obs = {st_c, pr_c, rl_c, hd_c};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL invert edge %0d: got %b want %b", e, obs, exp); end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_a  = 2'b00;
        in_b  = 2'b00;
        in_c  = 2'b10;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press();
        test_no_repeat();
        test_reset_mid();
        test_invert();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
